// File: rtl/bullet_pool.sv
// bullet_pool
//   Owns the player's bullets: N_BULLETS slots spawned from the ship and moved
//   upward once per frame. For each VGA pixel it reports (one cycle later)
//   whether the pixel lies inside a live bullet and the sprite-local (x,y) of
//   that pixel, which addresses the BW x BH bullet sprite ROM.
//
//   Optional build macro: BULLET_AUTOFIRE_EN
//     defined   -> fire is a level, sampled at frame ticks; no request latch
//     undefined -> a fire request is latched until a bullet actually spawns
//
// Ports
//   clk         pixel clock
//   rst_n       asynchronous active-low reset
//   frame_tick  one-cycle pulse per frame (vblank start)
//   fire        fire request
//   ship_x/y    ship top-left corner
//   pix_x/y     current VGA pixel
//   hit_clr     per-slot kill from collision logic (level or pulse)
//   active      per-slot live flags
//   fire_ack    one-cycle pulse the cycle after a bullet spawns
//   spr_hit     registered: previous pixel was inside a live bullet
//   spr_x/y     registered sprite-local coordinates (0 when no hit)
module bullet_pool #(
    parameter int N_BULLETS = 4,
    parameter int BW        = 11,
    parameter int BH        = 32,
    parameter int SPEED     = 4,
    parameter int COOLDOWN  = 8,
    parameter int SPAWN_DX  = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic                 fire,
    input  logic [9:0]           ship_x,
    input  logic [9:0]           ship_y,
    input  logic [9:0]           pix_x,
    input  logic [9:0]           pix_y,
    input  logic [N_BULLETS-1:0] hit_clr,
    output logic [N_BULLETS-1:0] active,
    output logic                 fire_ack,
    output logic                 spr_hit,
    output logic [9:0]           spr_x,
    output logic [9:0]           spr_y
);

    localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam int IW = (N_BULLETS < 2) ? 1 : $clog2(N_BULLETS);

    localparam logic [9:0]    SPEED_V = 10'(SPEED);
    localparam logic [9:0]    BH_V    = 10'(BH);
    localparam logic [9:0]    DX_V    = 10'(SPAWN_DX);
    localparam logic [10:0]   BW_W    = 11'(BW);
    localparam logic [10:0]   BH_W    = 11'(BH);
    localparam logic [CW-1:0] CD_V    = CW'(COOLDOWN);

    logic [9:0]    slot_x [N_BULLETS];
    logic [9:0]    slot_y [N_BULLETS];
    logic [CW-1:0] cooldown;

    logic          want;
    logic          spawn;
    logic          free_found;
    logic [IW-1:0] free_idx;
    logic [9:0]    spawn_x;
    logic [9:0]    spawn_y;

    logic          hit_n;
    logic [9:0]    sx_n;
    logic [9:0]    sy_n;

`ifdef BULLET_AUTOFIRE_EN
    assign want = fire;
`else
    logic fire_pend;

    assign want = fire | fire_pend;

    // A spawn consumes the request even if fire is still high that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fire_pend <= 1'b0;
        else if (spawn)
            fire_pend <= 1'b0;
        else if (fire)
            fire_pend <= 1'b1;
    end
`endif

    // Lowest free slot; a slot being killed this cycle is not eligible, and
    // slots retired by the move on this tick were still active beforehand.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (!active[i] && !hit_clr[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    assign spawn   = frame_tick & want & (cooldown == '0) & free_found;
    assign spawn_x = ship_x + DX_V;
    assign spawn_y = (ship_y < BH_V) ? 10'd0 : ship_y - BH_V;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= '0;
            for (int i = 0; i < N_BULLETS; i++) begin
                slot_x[i] <= '0;
                slot_y[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BULLETS; i++) begin
                if (hit_clr[i]) begin
                    active[i] <= 1'b0;
                end else if (spawn && (free_idx == IW'(i))) begin
                    active[i] <= 1'b1;
                    slot_x[i] <= spawn_x;
                    slot_y[i] <= spawn_y;
                end else if (frame_tick && active[i]) begin
                    // No wrap: a bullet that would cross row 0 retires.
                    if (slot_y[i] >= SPEED_V)
                        slot_y[i] <= slot_y[i] - SPEED_V;
                    else
                        active[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cooldown <= '0;
            fire_ack <= 1'b0;
        end else begin
            fire_ack <= spawn;
            if (spawn)
                cooldown <= CD_V;
            else if (frame_tick && (cooldown != '0))
                cooldown <= cooldown - 1'b1;
        end
    end

    // Pixel lookup against pre-update slot state; 11-bit compares keep
    // x+BW / y+BH from wrapping near the right/bottom edge.
    always_comb begin
        hit_n = 1'b0;
        sx_n  = '0;
        sy_n  = '0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (active[i] &&
                ({1'b0, pix_x} >= {1'b0, slot_x[i]}) &&
                ({1'b0, pix_x} <  ({1'b0, slot_x[i]} + BW_W)) &&
                ({1'b0, pix_y} >= {1'b0, slot_y[i]}) &&
                ({1'b0, pix_y} <  ({1'b0, slot_y[i]} + BH_W))) begin
                hit_n = 1'b1;
                sx_n  = pix_x - slot_x[i];
                sy_n  = pix_y - slot_y[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spr_hit <= 1'b0;
            spr_x   <= '0;
            spr_y   <= '0;
        end else begin
            spr_hit <= hit_n;
            spr_x   <= sx_n;
            spr_y   <= sy_n;
        end
    end

endmodule

// File: tb/tb_bullet_pool.sv
module tb_bullet_pool;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       fire = 1'b0;
    logic [9:0] ship_x = '0;
    logic [9:0] ship_y = '0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic [3:0] hit_clr = '0;
    logic [3:0] active;
    logic       fire_ack;
    logic       spr_hit;
    logic [9:0] spr_x;
    logic [9:0] spr_y;

    int checks = 0;
    int passes = 0;

    // reference model state (spec-level, plain integers)
    bit m_act [4];
    int m_x   [4];
    int m_y   [4];
    int m_cd;
    bit m_pend;

    // expectations produced by the last cycle() call
    bit         e_ack;
    bit         e_hit;
    int         e_sx;
    int         e_sy;
    logic [3:0] e_active;

    bullet_pool dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .fire      (fire),
        .ship_x    (ship_x),
        .ship_y    (ship_y),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .hit_clr   (hit_clr),
        .active    (active),
        .fire_ack  (fire_ack),
        .spr_hit   (spr_hit),
        .spr_x     (spr_x),
        .spr_y     (spr_y)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 0;
            m_x[i]   = 0;
            m_y[i]   = 0;
        end
        m_cd   = 0;
        m_pend = 0;
        e_ack  = 0;
        e_hit  = 0;
        e_sx   = 0;
        e_sy   = 0;
        e_active = '0;
    endfunction

    task automatic do_reset();
        frame_tick = 0;
        fire       = 0;
        hit_clr    = '0;
        pix_x      = '0;
        pix_y      = '0;
        rst_n      = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    // Drive one clock of stimulus and advance the model by one clock.
    task automatic cycle(input bit t, input bit f, input logic [3:0] hc,
                         input int px, input int py);
        bit   want;
        bit   found;
        int   slot;
        int   sx;
        int   sy;
        frame_tick = t;
        fire       = f;
        hit_clr    = hc;
        pix_x      = 10'(px);
        pix_y      = 10'(py);

        // pixel result reflects the bullets as they are before this edge
        found = 0;
        e_hit = 0;
        e_sx  = 0;
        e_sy  = 0;
        for (int i = 0; i < 4; i++) begin
            if (!found && m_act[i] && px >= m_x[i] && px < m_x[i] + 11 &&
                py >= m_y[i] && py < m_y[i] + 32) begin
                found = 1;
                e_hit = 1;
                e_sx  = px - m_x[i];
                e_sy  = py - m_y[i];
            end
        end

`ifdef BULLET_AUTOFIRE_EN
        want = f;
`else
        want = f || m_pend;
`endif
        slot = -1;
        for (int i = 0; i < 4; i++)
            if (slot < 0 && !m_act[i] && !hc[i]) slot = i;
        sx = (int'(ship_x) + 26) % 1024;
        sy = (int'(ship_y) < 32) ? 0 : int'(ship_y) - 32;

        for (int i = 0; i < 4; i++) begin
            if (hc[i]) m_act[i] = 0;
            else if (t && m_act[i]) begin
                if (m_y[i] >= 4) m_y[i] = m_y[i] - 4;
                else m_act[i] = 0;
            end
        end
        e_ack = 0;
        if (t && want && m_cd == 0 && slot >= 0) begin
            m_act[slot] = 1;
            m_x[slot]   = sx;
            m_y[slot]   = sy;
            m_cd        = 8;
            m_pend      = 0;
            e_ack       = 1;
        end else begin
            if (t && m_cd > 0) m_cd = m_cd - 1;
            if (f) m_pend = 1;
        end
        for (int i = 0; i < 4; i++) e_active[i] = m_act[i];

        @(posedge clk);
        #1;
        frame_tick = 0;
        fire       = 0;
        hit_clr    = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (active !== 4'b0000) $display("FAIL reset_active: got %b expected 0000", active); else passes++;
        checks++; if (fire_ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", fire_ack); else passes++;
        checks++; if (spr_hit !== 1'b0) $display("FAIL reset_hit: got %b expected 0", spr_hit); else passes++;
        checks++; if (spr_x !== 10'd0) $display("FAIL reset_sx: got %0d expected 0", spr_x); else passes++;
        checks++; if (spr_y !== 10'd0) $display("FAIL reset_sy: got %0d expected 0", spr_y); else passes++;
    endtask

    task automatic test_spawn();
        do_reset();
        ship_x = 10'd100;
        ship_y = 10'd400;
        cycle(0, 1, 4'b0000, 0, 0);
        checks++; if (fire_ack !== 1'b0) $display("FAIL spawn_no_early_ack: got %b expected 0", fire_ack); else passes++;
        cycle(1, 1, 4'b0000, 0, 0);
        checks++; if (fire_ack !== 1'b1) $display("FAIL spawn_ack: got %b expected 1", fire_ack); else passes++;
        checks++; if (active !== 4'b0001) $display("FAIL spawn_active: got %b expected 0001", active); else passes++;
        cycle(0, 0, 4'b0000, 130, 370);
        checks++; if (fire_ack !== 1'b0) $display("FAIL spawn_ack_pulse: got %b expected 0", fire_ack); else passes++;
        checks++; if ({spr_hit, spr_x, spr_y} !== {1'b1, 10'd4, 10'd2})
            $display("FAIL pix_inside: got hit=%b x=%0d y=%0d expected hit=1 x=4 y=2", spr_hit, spr_x, spr_y); else passes++;
        cycle(0, 0, 4'b0000, 137, 370);
        checks++; if ({spr_hit, spr_x, spr_y} !== {1'b0, 10'd0, 10'd0})
            $display("FAIL pix_right_edge: got hit=%b x=%0d y=%0d expected hit=0 x=0 y=0", spr_hit, spr_x, spr_y); else passes++;
        cycle(0, 0, 4'b0000, 136, 399);
        checks++; if ({spr_hit, spr_x, spr_y} !== {1'b1, 10'd10, 10'd31})
            $display("FAIL pix_corner: got hit=%b x=%0d y=%0d expected hit=1 x=10 y=31", spr_hit, spr_x, spr_y); else passes++;
        cycle(0, 0, 4'b0000, 126, 367);
        checks++; if (spr_hit !== 1'b0) $display("FAIL pix_above: got %b expected 0", spr_hit); else passes++;
    endtask

    task automatic test_top_edge();
        do_reset();
        ship_x = 10'd100;
        ship_y = 10'd34;
        cycle(0, 1, 4'b0000, 0, 0);
        cycle(1, 0, 4'b0000, 0, 0);
        checks++; if (active !== 4'b0001) $display("FAIL y2_spawn: got %b expected 0001", active); else passes++;
        cycle(1, 0, 4'b0000, 0, 0);
        checks++; if (active[0] !== 1'b0) $display("FAIL y2_retire: got %b expected 0", active[0]); else passes++;

        do_reset();
        ship_y = 10'd36;
        cycle(0, 1, 4'b0000, 0, 0);
        cycle(1, 0, 4'b0000, 0, 0);
        cycle(1, 0, 4'b0000, 126, 0);
        checks++; if (active[0] !== 1'b1) $display("FAIL y4_kept: got %b expected 1", active[0]); else passes++;
        cycle(0, 0, 4'b0000, 126, 0);
        checks++; if ({spr_hit, spr_x, spr_y} !== {1'b1, 10'd0, 10'd0})
            $display("FAIL y0_pixel: got hit=%b x=%0d y=%0d expected hit=1 x=0 y=0", spr_hit, spr_x, spr_y); else passes++;
        cycle(1, 0, 4'b0000, 0, 0);
        checks++; if (active[0] !== 1'b0) $display("FAIL y0_retire: got %b expected 0", active[0]); else passes++;

        // ship near the top-right: y clamps to 0, x wraps in 10 bits
        do_reset();
        ship_x = 10'd1020;
        ship_y = 10'd10;
        cycle(0, 1, 4'b0000, 0, 0);
        cycle(1, 0, 4'b0000, 0, 0);
        cycle(0, 0, 4'b0000, 32, 31);
        checks++; if ({spr_hit, spr_x, spr_y} !== {1'b1, 10'd10, 10'd31})
            $display("FAIL clamp_wrap: got hit=%b x=%0d y=%0d expected hit=1 x=10 y=31", spr_hit, spr_x, spr_y); else passes++;
    endtask

    task automatic test_cooldown();
        int n;
        do_reset();
        ship_x = 10'd100;
        ship_y = 10'd400;
        for (int k = 0; k < 20; k++) begin
            cycle(1, 1, 4'b0000, 0, 0);
            checks++;
            if (fire_ack !== ((k == 0) || (k == 9) || (k == 18)))
                $display("FAIL cooldown_tick%0d: got %b expected %b", k, fire_ack, (k == 0) || (k == 9) || (k == 18));
            else passes++;
        end
        n = 0;
        while (e_active != 4'b1111 && n < 60) begin
            cycle(1, 1, 4'b0000, 0, 0);
            n++;
        end
        checks++; if (active !== 4'b1111) $display("FAIL fill_all: got %b expected 1111", active); else passes++;
        repeat (9) cycle(1, 0, 4'b0000, 0, 0);
        cycle(1, 1, 4'b0000, 0, 0);
        checks++; if (fire_ack !== 1'b0) $display("FAIL full_no_ack: got %b expected 0", fire_ack); else passes++;
        cycle(1, 0, 4'b0000, 0, 0);
        checks++; if (fire_ack !== 1'b0) $display("FAIL full_pend_hold: got %b expected 0", fire_ack); else passes++;
        cycle(0, 0, 4'b0100, 0, 0);
        checks++; if (active !== 4'b1011) $display("FAIL kill_slot2: got %b expected 1011", active); else passes++;
        cycle(1, 0, 4'b0000, 0, 0);
        checks++; if (fire_ack !== e_ack) $display("FAIL free_ack_model: got %b expected %b", fire_ack, e_ack); else passes++;
`ifndef BULLET_AUTOFIRE_EN
        checks++; if ({fire_ack, active} !== {1'b1, 4'b1111})
            $display("FAIL pend_serviced: got ack=%b act=%b expected ack=1 act=1111", fire_ack, active); else passes++;
`endif
    endtask

    task automatic test_hitclr_spawn();
        do_reset();
        ship_x = 10'd100;
        ship_y = 10'd400;
        cycle(0, 1, 4'b0000, 0, 0);
        cycle(1, 1, 4'b0000, 0, 0);
        repeat (8) cycle(1, 0, 4'b0000, 0, 0);
        cycle(0, 1, 4'b0000, 0, 0);
        cycle(1, 1, 4'b0001, 0, 0);
        checks++; if (active !== 4'b0010) $display("FAIL hitclr_slot: got %b expected 0010", active); else passes++;
        checks++; if (fire_ack !== 1'b1) $display("FAIL hitclr_ack: got %b expected 1", fire_ack); else passes++;
    endtask

    task automatic test_overlap_reset();
        do_reset();
        ship_x = 10'd100;
        ship_y = 10'd400;
        cycle(0, 1, 4'b0000, 0, 0);
        cycle(1, 1, 4'b0000, 0, 0);
        repeat (8) cycle(1, 0, 4'b0000, 0, 0);
        ship_y = 10'd384;
        cycle(1, 1, 4'b0000, 0, 0);
        checks++; if (active !== 4'b0011) $display("FAIL overlap_setup: got %b expected 0011", active); else passes++;
        cycle(0, 0, 4'b0000, 130, 355);
        checks++; if ({spr_hit, spr_x, spr_y} !== {1'b1, 10'd4, 10'd23})
            $display("FAIL overlap_prio: got hit=%b x=%0d y=%0d expected hit=1 x=4 y=23", spr_hit, spr_x, spr_y); else passes++;
        #2;
        rst_n = 0;
        #1;
        checks++; if ({active, fire_ack, spr_hit, spr_x, spr_y} !== '0)
            $display("FAIL async_reset: got act=%b ack=%b hit=%b x=%0d y=%0d expected all 0",
                     active, fire_ack, spr_hit, spr_x, spr_y); else passes++;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        ship_y = 10'd400;
        cycle(0, 1, 4'b0000, 0, 0);
        cycle(1, 0, 4'b0000, 0, 0);
        checks++; if ({fire_ack, active} !== {1'b1, 4'b0001})
            $display("FAIL post_reset_spawn: got ack=%b act=%b expected ack=1 act=0001", fire_ack, active); else passes++;
    endtask

    task automatic test_random();
        bit         t;
        bit         f;
        logic [3:0] hc;
        int         px;
        int         py;
        int         j;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            t  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 1) == 0);
            hc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            ship_x = 10'($urandom_range(0, 1023));
            ship_y = 10'($urandom_range(0, 479));
            j  = $urandom_range(0, 3);
            if (m_act[j] && $urandom_range(0, 3) != 0) begin
                px = m_x[j] + $urandom_range(0, 13) - 1;
                py = m_y[j] + $urandom_range(0, 34) - 1;
                if (px < 0) px = 0;
                if (px > 1023) px = 1023;
                if (py < 0) py = 0;
                if (py > 1023) py = 1023;
            end else begin
                px = $urandom_range(0, 1023);
                py = $urandom_range(0, 1023);
            end
            cycle(t, f, hc, px, py);
            checks++; if (active !== e_active) $display("FAIL rnd_active[%0d]: got %b expected %b", n, active, e_active); else passes++;
            checks++; if (fire_ack !== e_ack) $display("FAIL rnd_ack[%0d]: got %b expected %b", n, fire_ack, e_ack); else passes++;
            checks++; if ({spr_hit, spr_x, spr_y} !== {e_hit, 10'(e_sx), 10'(e_sy)})
                $display("FAIL rnd_pixel[%0d]: got hit=%b x=%0d y=%0d expected hit=%b x=%0d y=%0d",
                         n, spr_hit, spr_x, spr_y, e_hit, e_sx, e_sy); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_top_edge();
        test_cooldown();
        test_hitclr_spawn();
        test_overlap_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
